// File: rtl/arbitro_memoria_if.sv
// ---------------------------------------------------------------------------
// arbitro_memoria_if
// Bundle of every signal exchanged between the unified-memory arbiter, the
// two pipeline requesters (fetch and memory stage) and the single memory port.
//
// Modports:
//   master - used by the arbiter: reads the requests and ram_rdata, drives
//            the responses, the stalls and the memory port.
//   slave  - used by the surrounding pipeline/memory: the mirror image.
//
// Signals:
//   if_req / if_addr                     fetch request and PC
//   if_rdata / if_done                   fetched word and completion pulse
//   mem_rd / mem_wr / mem_addr / mem_wdata   load/store request
//   mem_rdata / mem_done                 load data and completion pulse
//   stall_if / stall_mem                 combinational stage stalls
//   ram_en / ram_we / ram_addr / ram_wdata / ram_rdata   memory port
// ---------------------------------------------------------------------------
interface arbitro_memoria_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              stall_if;
    logic              stall_mem;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_rdata,
        output if_rdata, if_done, mem_rdata, mem_done, stall_if, stall_mem,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_rdata,
        input  if_rdata, if_done, mem_rdata, mem_done, stall_if, stall_mem,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/arbitro_memoria.sv
// ---------------------------------------------------------------------------
// arbitro_memoria
// Shares one single-port memory between the fetch stage and the memory stage.
// Each granted access holds ram_en for MEM_LAT cycles, then a one-cycle RESP
// state pulses the requester's done flag before the next grant is sampled.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   reset  - synchronous active-high reset
//   bus    - arbitro_memoria_if.master: requests, responses, stalls and the
//            memory port
//
// Configuration macro:
//   ARBITRO_RR_EN - when defined, simultaneous requests alternate between the
//                   two ports (round robin); otherwise data always beats fetch.
// ---------------------------------------------------------------------------
module arbitro_memoria #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic               clk,
    input  logic               reset,
    arbitro_memoria_if.master  bus
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, RESP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_mem_q, owner_mem_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

    logic req_mem;
    logic req_if;
    logic grant_mem;
    logic busy;
    logic if_done;
    logic mem_done;

    // Request decode and priority. owner_mem_q remembers which port owns the
    // current (or most recent) access, so in round-robin mode it doubles as the
    // last-granted flag: on a collision the port that did not go last wins.
    always_comb begin
        req_mem = bus.mem_rd | bus.mem_wr;
        req_if  = bus.if_req;
`ifdef ARBITRO_RR_EN
        grant_mem = req_mem & (~req_if | ~owner_mem_q);
`else
        grant_mem = req_mem;
`endif
    end

    // State, counter and data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_mem_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_mem_q <= owner_mem_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Next-state logic. The grant latches address, data and write flag once,
    // so requester inputs are ignored for the rest of the access. Read data is
    // captured on the last busy cycle; a store leaves mem_rdata untouched.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_mem_d = owner_mem_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            IDLE: begin
                if (req_mem | req_if) begin
                    owner_mem_d = grant_mem;
                    we_d        = grant_mem & bus.mem_wr;
                    addr_d      = grant_mem ? bus.mem_addr : bus.if_addr;
                    wdata_d     = bus.mem_wdata;
                    cnt_d       = CNT_LOAD;
                    state_d     = grant_mem ? BUSY_MEM : BUSY_IF;
                end
            end
            BUSY_IF, BUSY_MEM: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (state_q == BUSY_IF) begin
                        if_rdata_d = bus.ram_rdata;
                    end else if (!we_q) begin
                        mem_rdata_d = bus.ram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs. Stalls are purely combinational so the stage freezes in the
    // same cycle it raises its request and releases in the done cycle.
    always_comb begin
        busy     = (state_q == BUSY_IF) || (state_q == BUSY_MEM);
        if_done  = (state_q == RESP) && !owner_mem_q;
        mem_done = (state_q == RESP) && owner_mem_q;
    end

    assign bus.ram_en    = busy;
    assign bus.ram_we    = busy & we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.if_done   = if_done;
    assign bus.mem_done  = mem_done;
    assign bus.stall_if  = bus.if_req & ~if_done;
    assign bus.stall_mem = (bus.mem_rd | bus.mem_wr) & ~mem_done;

endmodule

// File: tb/tb_arbitro_memoria.sv
// ---------------------------------------------------------------------------
// tb_arbitro_memoria
// Drives arbitro_memoria with directed scenarios followed by random traffic.
// A transaction-level model (grant cycle + fixed latency arithmetic, shadow
// memory) predicts every output each cycle; directed scenarios also pin a few
// hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_arbitro_memoria;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MEM_LAT = 2;

    logic clk;
    logic reset;

    arbitro_memoria_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    arbitro_memoria #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Memory behind the port, and the model's own view of what it must hold.
    logic [31:0] ram    [logic [31:0]];
    logic [31:0] refMem [logic [31:0]];

    // Model state: one outstanding access described by its grant cycle.
    int          cyc = 0;
    bit          started = 0;
    bit          mBusy = 0;
    int          gT = 0;
    bit          gMem = 0;
    bit          gWe = 0;
    logic [31:0] gAddr = '0;
    logic [31:0] gWdata = '0;
    logic [31:0] gData = '0;
    logic [31:0] expIf = '0;
    logic [31:0] expMem = '0;
    bit          lastMem = 0;

    bit active;
    bit doneNow;
    bit expIfDone;
    bit expMemDone;

    function automatic logic [31:0] initWord(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    function automatic logic [31:0] ramRead(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return initWord(a);
    endfunction

    function automatic logic [31:0] refRead(input logic [31:0] a);
        if (refMem.exists(a)) return refMem[a];
        return initWord(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a request seen while idle starts an access lasting
    // MEM_LAT enabled cycles, a done cycle, and then the port is free again.
    always @(posedge clk) begin
        if (reset) begin
            mBusy   = 0;
            expIf   = '0;
            expMem  = '0;
            lastMem = 0;
            started = 1;
        end else begin
            if (mBusy && cyc == gT + MEM_LAT && !gWe) begin
                if (gMem) expMem = gData;
                else      expIf  = gData;
            end
            if (!mBusy || cyc >= gT + MEM_LAT + 2) begin
                bit wantMem;
                bit wantIf;
                bit pickMem;
                mBusy   = 0;
                wantMem = bus.mem_rd | bus.mem_wr;
                wantIf  = bus.if_req;
`ifdef ARBITRO_RR_EN
                pickMem = wantMem && (!wantIf || !lastMem);
`else
                pickMem = wantMem;
`endif
                if (wantMem || wantIf) begin
                    mBusy   = 1;
                    gT      = cyc;
                    gMem    = pickMem;
                    gWe     = pickMem && bus.mem_wr;
                    gAddr   = pickMem ? bus.mem_addr : bus.if_addr;
                    gWdata  = bus.mem_wdata;
                    lastMem = pickMem;
                    if (gWe) begin
                        refMem[gAddr] = gWdata;
                        gData = '0;
                    end else begin
                        gData = refRead(gAddr);
                    end
                end
            end
        end
        cyc++;
    end

    // Memory port: stores land on the enabled cycles; read data is only valid
    // in the last enabled cycle of a read, garbage at any other time.
    always @(negedge clk) begin
        if (bus.ram_en === 1'b1 && bus.ram_we === 1'b1) ram[bus.ram_addr] = bus.ram_wdata;
        if (mBusy && cyc == gT + MEM_LAT) bus.ram_rdata = ramRead(bus.ram_addr);
        else                               bus.ram_rdata = $urandom;
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        if (started) begin
            active     = mBusy && cyc >= gT + 1 && cyc <= gT + MEM_LAT;
            doneNow    = mBusy && cyc == gT + MEM_LAT + 1;
            expIfDone  = doneNow && !gMem;
            expMemDone = doneNow && gMem;
            check("ram_en",    32'(bus.ram_en),    32'(active));
            check("ram_we",    32'(bus.ram_we),    32'(active && gWe));
            check("if_done",   32'(bus.if_done),   32'(expIfDone));
            check("mem_done",  32'(bus.mem_done),  32'(expMemDone));
            check("if_rdata",  bus.if_rdata,       expIf);
            check("mem_rdata", bus.mem_rdata,      expMem);
            check("stall_if",  32'(bus.stall_if),  32'(bus.if_req && !expIfDone));
            check("stall_mem", 32'(bus.stall_mem), 32'((bus.mem_rd || bus.mem_wr) && !expMemDone));
            if (active) check("ram_addr", bus.ram_addr, gAddr);
            if (active && gWe) check("ram_wdata", bus.ram_wdata, gWdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input bit ifReq, input logic [31:0] ifAddr, input bit rd,
                                 input bit wr, input logic [31:0] mAddr, input logic [31:0] wdata);
        bus.if_req    = ifReq;
        bus.if_addr   = ifAddr;
        bus.mem_rd    = rd;
        bus.mem_wr    = wr;
        bus.mem_addr  = mAddr;
        bus.mem_wdata = wdata;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, act, exp);
    endtask

    int order [4];
    int nDone;
`ifdef ARBITRO_RR_EN
    int expOrder [4] = '{1, 0, 1, 0};
`else
    int expOrder [4] = '{1, 1, 1, 1};
`endif

    initial begin
        ram[32'h10]    = 32'h8C220004;
        refMem[32'h10] = 32'h8C220004;
        reset = 1'b1;
        applyStimulus(0, '0, 0, 0, '0, '0);
        repeat (3) tick();
        reset = 1'b0;

        // Reset state.
        sample();
        checkOutput("rst ram_en",    32'(bus.ram_en), 32'h0);
        checkOutput("rst ram_addr",  bus.ram_addr,    32'h0);
        checkOutput("rst ram_wdata", bus.ram_wdata,   32'h0);
        checkOutput("rst if_rdata",  bus.if_rdata,    32'h0);
        checkOutput("rst mem_rdata", bus.mem_rdata,   32'h0);

        // Single fetch, with the PC changing while the access is in flight.
        tick(); applyStimulus(1, 32'h10, 0, 0, '0, '0);
        sample(); checkOutput("fetch stall T", 32'(bus.stall_if), 32'h1);
        tick(); bus.if_addr = 32'h20;
        sample(); checkOutput("fetch addr T+1", bus.ram_addr, 32'h10);
                  checkOutput("fetch en T+1",   32'(bus.ram_en), 32'h1);
        tick();
        sample(); checkOutput("fetch addr T+2", bus.ram_addr, 32'h10);
                  checkOutput("fetch stall T+2", 32'(bus.stall_if), 32'h1);
        tick();
        sample(); checkOutput("fetch done T+3", 32'(bus.if_done), 32'h1);
                  checkOutput("fetch data T+3", bus.if_rdata, 32'h8C220004);
                  checkOutput("fetch stall T+3", 32'(bus.stall_if), 32'h0);
        tick(); applyStimulus(0, '0, 0, 0, '0, '0);
        repeat (2) tick();

        // Collision: store beats fetch.
        applyStimulus(1, 32'h14, 0, 1, 32'h40, 32'hDEADBEEF);
        tick();
        sample(); checkOutput("coll we T+1",   32'(bus.ram_we), 32'h1);
                  checkOutput("coll addr T+1", bus.ram_addr, 32'h40);
        tick();
        sample(); checkOutput("coll wdata T+2", bus.ram_wdata, 32'hDEADBEEF);
        tick();
        sample(); checkOutput("coll mem_done T+3", 32'(bus.mem_done), 32'h1);
        tick(); bus.mem_wr = 0;
        repeat (3) tick();
        sample(); checkOutput("coll if_done T+7", 32'(bus.if_done), 32'h1);
        tick(); applyStimulus(0, '0, 0, 0, '0, '0);
        repeat (2) tick();

        // Back-to-back collisions: record the order of completions.
        applyStimulus(1, 32'h10, 1, 0, 32'h84, '0);
        nDone = 0;
        for (int i = 0; i < 40 && nDone < 4; i++) begin
            sample();
            if (bus.mem_done === 1'b1) begin order[nDone] = 1; nDone++; end
            else if (bus.if_done === 1'b1) begin order[nDone] = 0; nDone++; end
            tick();
        end
        applyStimulus(0, '0, 0, 0, '0, '0);
        checkOutput("rr done count", 32'(nDone), 32'd4);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("grant order %0d", i), 32'(order[i]), 32'(expOrder[i]));
        repeat (2) tick();

        // Store then load the same word.
        applyStimulus(0, '0, 0, 1, 32'h80, 32'h12345678);
        repeat (3) tick();
        sample(); checkOutput("store done", 32'(bus.mem_done), 32'h1);
                  checkOutput("store keeps rdata", bus.mem_rdata, initWord(32'h84));
        tick(); applyStimulus(0, '0, 1, 0, 32'h80, '0);
        repeat (3) tick();
        sample(); checkOutput("load done", 32'(bus.mem_done), 32'h1);
                  checkOutput("load data", bus.mem_rdata, 32'h12345678);
        tick(); applyStimulus(0, '0, 0, 0, '0, '0);
        repeat (2) tick();

        // Reset in the middle of a fetch.
        applyStimulus(1, 32'h30, 0, 0, '0, '0);
        tick(); reset = 1'b1;
        sample(); checkOutput("mid en T+1", 32'(bus.ram_en), 32'h1);
        tick(); reset = 1'b0; bus.if_req = 0;
        sample(); checkOutput("mid en T+2",     32'(bus.ram_en), 32'h0);
                  checkOutput("mid addr T+2",   bus.ram_addr,    32'h0);
                  checkOutput("mid if_rdata",   bus.if_rdata,    32'h0);
                  checkOutput("mid mem_rdata",  bus.mem_rdata,   32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            sample(); checkOutput("mid no done", 32'(bus.if_done), 32'h0);
        end
        tick(); applyStimulus(1, 32'h10, 0, 0, '0, '0);
        repeat (3) tick();
        sample(); checkOutput("post-reset done", 32'(bus.if_done), 32'h1);
                  checkOutput("post-reset data", bus.if_rdata, 32'h8C220004);
        tick(); applyStimulus(0, '0, 0, 0, '0, '0);
        tick();

        // Random traffic; inputs change every cycle, including mid-access.
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            bus.if_req    = ($urandom_range(0, 9) < 6);
            bus.if_addr   = 32'h80 + 32'($urandom_range(0, 7)) * 4;
            bus.mem_rd    = (r < 2) || (r == 4);
            bus.mem_wr    = (r >= 2 && r <= 4);
            bus.mem_addr  = 32'h80 + 32'($urandom_range(0, 7)) * 4;
            bus.mem_wdata = $urandom;
            tick();
        end
        applyStimulus(0, '0, 0, 0, '0, '0);
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
